// File: rtl/arm_regfile_mp.sv
// arm_regfile_mp: decode-stage register file with three read ports and two
// write ports. Port A carries ALU results and port B carries load data.
// It also provides a branch-with-link write, a PC read path, optional
// write-to-read bypass, and a pending-load scoreboard that drives stall.
module arm_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 15,
  parameter int LR_IDX = 14,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    re1,
  input  logic                    re2,
  input  logic                    re3,
  input  logic [ADDR_W-1:0]       ra1,
  input  logic [ADDR_W-1:0]       ra2,
  input  logic [ADDR_W-1:0]       ra3,
  output logic [DATA_W-1:0]       rd1,
  output logic [DATA_W-1:0]       rd2,
  output logic [DATA_W-1:0]       rd3,
  input  logic                    we_a,
  input  logic [ADDR_W-1:0]       wa_a,
  input  logic [DATA_W-1:0]       wd_a,
  input  logic                    we_b,
  input  logic [ADDR_W-1:0]       wa_b,
  input  logic [DATA_W-1:0]       wd_b,
  input  logic                    link_we,
  input  logic [DATA_W-1:0]       pc_plus8,
  input  logic                    busy_set,
  input  logic [ADDR_W-1:0]       busy_idx,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic                    stall
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);

  logic [DATA_W-1:0] regs_q  [NREGS];
  logic              wr_en_d [NREGS];
  logic [DATA_W-1:0] wr_dat_d[NREGS];
  logic [DATA_W-1:0] link_data;
  logic [NREGS-1:0]  busy_q, busy_d;

  logic [ADDR_W-1:0] rd_addr [3];
  logic              rd_en   [3];
  logic [DATA_W-1:0] rd_data [3];

  assign rd_addr[0] = ra1;
  assign rd_addr[1] = ra2;
  assign rd_addr[2] = ra3;
  assign rd_en[0]   = re1;
  assign rd_en[1]   = re2;
  assign rd_en[2]   = re3;
  assign rd1        = rd_data[0];
  assign rd2        = rd_data[1];
  assign rd3        = rd_data[2];
  assign busy       = busy_q;

  // The link write stores the return address, which is PC + 4 (wraps modulo 2**DATA_W).
  assign link_data = pc_plus8 - DATA_W'(4);

  // Resolve the winning write per register: port B, then link, then port A.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: every always_comb output gets a default first, so no path leaves a latch.
      wr_en_d[i]  = 1'b0;
      wr_dat_d[i] = '0;
      if (we_b && wa_b == ADDR_W'(i)) begin
        wr_en_d[i]  = 1'b1;
        wr_dat_d[i] = wd_b;
      end else if (link_we && LR_A == ADDR_W'(i)) begin
        wr_en_d[i]  = 1'b1;
        wr_dat_d[i] = link_data;
      end else if (we_a && wa_a == ADDR_W'(i)) begin
        wr_en_d[i]  = 1'b1;
        wr_dat_d[i] = wd_a;
      end
      // The PC has no storage behind it, so writes to its index are dropped.
      if (ADDR_W'(i) == PC_A) wr_en_d[i] = 1'b0;
    end
  end

  // Commit the winning writes; reset clears the whole array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this array is reset on purpose because software expects all registers to be zero after reset.
      // The cost is that it cannot map onto RAM macros.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: use non-blocking assignments for state, so every register samples pre-edge values.
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en_d[i]) regs_q[i] <= wr_dat_d[i];
      end
    end
  end

  // Scoreboard next state: a load writeback clears the bit, then busy_set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (we_b) busy_d[wa_b] = 1'b0;
    if (busy_set && busy_idx != PC_A) busy_d[busy_idx] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Read muxes: the PC index reads pc_plus8, otherwise return the stored value or the bypassed value.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_data[k] = regs_q[rd_addr[k]];
      if (rd_addr[k] == PC_A) begin
        rd_data[k] = pc_plus8;
      end else if (BYPASS != 0 && !reset && wr_en_d[rd_addr[k]]) begin
        rd_data[k] = wr_dat_d[rd_addr[k]];
      end
    end
  end

  // Hazard detect: a valid read of a pending register stalls the pipeline.
  // With bypass, a load landing this cycle resolves the hazard.
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k] && busy_q[rd_addr[k]] && rd_addr[k] != PC_A &&
          !(BYPASS != 0 && we_b && wa_b == rd_addr[k]))
        stall = 1'b1;
    end
    if (reset) stall = 1'b0;
  end

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Directed testbench for arm_regfile_mp.
// Two instances share all inputs: one built with bypass and one without,
// so that bypass and no-bypass behaviour can be compared in the same cycle.
module tb_arm_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          re1, re2, re3;
  logic [AW-1:0] ra1, ra2, ra3;
  logic          we_a, we_b, link_we, busy_set;
  logic [AW-1:0] wa_a, wa_b, busy_idx;
  logic [DW-1:0] wd_a, wd_b, pc_plus8;

  logic [DW-1:0] b_rd1, b_rd2, b_rd3, n_rd1, n_rd2, n_rd3;
  logic [NR-1:0] b_busy, n_busy;
  logic          b_stall, n_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arm_regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .re1(re1), .re2(re2), .re3(re3),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(b_rd1), .rd2(b_rd2), .rd3(b_rd3),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .link_we(link_we), .pc_plus8(pc_plus8),
    .busy_set(busy_set), .busy_idx(busy_idx),
    .busy(b_busy), .stall(b_stall)
  );

  arm_regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .re1(re1), .re2(re2), .re3(re3),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(n_rd1), .rd2(n_rd2), .rd3(n_rd3),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .link_we(link_we), .pc_plus8(pc_plus8),
    .busy_set(busy_set), .busy_idx(busy_idx),
    .busy(n_busy), .stall(n_stall)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Step past the next rising edge; inputs are changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re1 = 0; re2 = 0; re3 = 0;
    we_a = 0; we_b = 0; link_we = 0; busy_set = 0;
    wa_a = '0; wa_b = '0; busy_idx = '0;
    wd_a = '0; wd_b = '0;
  endtask

  initial begin
    reset = 1'b1;
    ra1 = '0; ra2 = '0; ra3 = '0; pc_plus8 = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    ra1 = 4'd3;
    #1;
    check("reset_rd1", b_rd1, 0);
    check("reset_busy", b_busy, 0);

    // Write R3 and mark it busy, then assert reset asynchronously mid-cycle.
    we_a = 1; wa_a = 4'd3; wd_a = 32'hDEADBEEF; busy_set = 1; busy_idx = 4'd3;
    tick();
    idle();
    re1 = 1;
    #1;
    check("pre_rst_rd1", b_rd1, 32'hDEADBEEF);
    check("pre_rst_busy", b_busy, 16'h0008);
    check("pre_rst_stall", b_stall, 1);
    #2;
    reset = 1'b1;
    ra3 = 4'd15; pc_plus8 = 32'h0000_1008;
    #1;
    check("async_rst_rd1", b_rd1, 0);
    check("async_rst_busy", b_busy, 0);
    check("async_rst_stall", b_stall, 0);
    check("async_rst_pc", b_rd3, 32'h0000_1008);
    tick();
    reset = 1'b0;
    idle();

    // Port A and port B write the same index: port B wins, and is bypassed only when enabled.
    we_a = 1; wa_a = 4'd5; wd_a = 32'h11;
    we_b = 1; wa_b = 4'd5; wd_b = 32'h22;
    ra1 = 4'd5;
    #1;
    check("ab_bypass_rd1", b_rd1, 32'h22);
    check("ab_nobyp_rd1", n_rd1, 32'h0);
    tick();
    idle();
    #1;
    check("ab_next_byp", b_rd1, 32'h22);
    check("ab_next_nob", n_rd1, 32'h22);

    // Link write stores pc_plus8 - 4 into R14.
    link_we = 1; pc_plus8 = 32'h108; ra2 = 4'd14;
    tick();
    idle();
    #1;
    check("link_rd2", b_rd2, 32'h104);
    check("link_rd2_nob", n_rd2, 32'h104);

    // The PC index reads pc_plus8, and a port A write to it is ignored.
    pc_plus8 = 32'h200; ra3 = 4'd15;
    we_a = 1; wa_a = 4'd15; wd_a = 32'h999;
    #1;
    check("pc_read_same", b_rd3, 32'h200);
    tick();
    idle();
    pc_plus8 = 32'h300;
    #1;
    check("pc_read_after", b_rd3, 32'h300);
    check("pc_read_nob", n_rd3, 32'h300);

    // Priority: link beats port A on R14; port B beats link on R14.
    link_we = 1; pc_plus8 = 32'h308; we_a = 1; wa_a = 4'd14; wd_a = 32'h33;
    tick();
    idle();
    #1;
    check("link_over_a", b_rd2, 32'h304);
    link_we = 1; pc_plus8 = 32'h408; we_b = 1; wa_b = 4'd14; wd_b = 32'h44;
    tick();
    idle();
    #1;
    check("b_over_link", n_rd2, 32'h44);

    // Scoreboard: set R7 busy, read it to get a stall, then resolve it with a load.
    busy_set = 1; busy_idx = 4'd7;
    tick();
    idle();
    re1 = 1; ra1 = 4'd7;
    #1;
    check("sb_stall_byp", b_stall, 1);
    check("sb_stall_nob", n_stall, 1);
    check("sb_busy7", b_busy[7], 1);
    re1 = 0;
    #1;
    check("sb_no_re", b_stall, 0);
    re1 = 1;
    we_b = 1; wa_b = 4'd7; wd_b = 32'h55;
    #1;
    check("sb_ld_byp_stall", b_stall, 0);
    check("sb_ld_nob_stall", n_stall, 1);
    check("sb_ld_byp_rd1", b_rd1, 32'h55);
    tick();
    idle();
    re1 = 1; ra1 = 4'd7;
    #1;
    check("sb_clr_busy", b_busy, 16'h0000);
    check("sb_clr_rd1", n_rd1, 32'h55);
    check("sb_clr_stall", n_stall, 0);

    // A set and a clear on the same index in the same cycle: the set wins. busy_set on PC_IDX is ignored.
    busy_set = 1; busy_idx = 4'd9; we_b = 1; wa_b = 4'd9; wd_b = 32'h99;
    tick();
    idle();
    busy_set = 1; busy_idx = 4'd15;
    tick();
    idle();
    #1;
    check("sb_set_wins", b_busy, 16'h0200);
    check("sb_set_wins_nob", n_busy, 16'h0200);
    re3 = 1; ra3 = 4'd9;
    #1;
    check("sb_re3_stall", b_stall, 1);
    re3 = 0;

    // Without bypass a write shows up only in the next cycle.
    we_a = 1; wa_a = 4'd2; wd_a = 32'h77; ra1 = 4'd2;
    #1;
    check("nob_old_rd1", n_rd1, 32'h0);
    check("byp_new_rd1", b_rd1, 32'h77);
    tick();
    idle();
    #1;
    check("nob_next_rd1", n_rd1, 32'h77);

    // Link with pc_plus8 = 0 wraps around to 0xFFFFFFFC.
    link_we = 1; pc_plus8 = 32'h0; ra2 = 4'd14;
    tick();
    idle();
    #1;
    check("link_wrap", n_rd2, 32'hFFFFFFFC);
    check("link_wrap_byp", b_rd2, 32'hFFFFFFFC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_regfile_mp.md
Name: arm_regfile_mp

Overview:
Parametrised next-generation ARM register file with three read ports and two write ports. Port A carries ALU results and port B carries load data. It adds a dedicated branch-with-link write, a PC read path, optional write-to-read bypass, and a pending-load scoreboard that raises a stall when a read hits a register still awaiting load data. It sits in the decode stage, between the instruction decoder and the execute/memory writeback paths.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register index width; NREGS = 2**ADDR_W
PC_IDX, 15, index that reads as the PC (not stored)
LR_IDX, 14, link register index
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = writes visible next cycle only

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
re1/re2/re3  in  1 each  read-port valid, used only for stall evaluation
ra1/ra2/ra3  in  ADDR_W each  read addresses
rd1/rd2/rd3  out  DATA_W each  read data
we_a  in  1  ALU write enable
wa_a  in  ADDR_W  ALU write index
wd_a  in  DATA_W  ALU write data
we_b  in  1  load write enable
wa_b  in  ADDR_W  load write index
wd_b  in  DATA_W  load write data
link_we  in  1  write pc_plus8 - 4 into LR_IDX
pc_plus8  in  DATA_W  current PC + 8
busy_set  in  1  mark a register as pending a load
busy_idx  in  ADDR_W  register to mark
busy  out  NREGS  scoreboard vector, one bit per register
stall  out  1  read hazard on a pending register

Behaviour:
- Reset (async, any time):
  - all stored registers and all busy bits cleared to 0 immediately;
  - rdN = 0 for non-PC indices and pc_plus8 for PC_IDX;
  - stall = 0.
  - Any write, link or busy_set in flight at reset is discarded.
- Reads are combinational.
  - raN == PC_IDX returns pc_plus8 directly.
  - Otherwise the read returns the stored value, or the bypassed value when BYPASS=1.
- Writes commit on the rising edge and are visible on the next cycle.
  - Write data is always DATA_W wide; no extension or truncation.
  - Link data is pc_plus8 - 4, modulo 2**DATA_W.
- Same-index write priority: port B > link > port A. Losing writes to that index are dropped.
- Writes to PC_IDX from any source are ignored; no storage exists for the PC.
- Bypass (BYPASS=1): a read of index i (i != PC_IDX) returns the winning write data when a write to i is in progress this cycle.
- Scoreboard:
  - busy_set sets busy[busy_idx] at the edge.
  - we_b clears busy[wa_b] at the edge.
  - Set and clear on the same index in the same cycle: set wins (a new load overwrites the pending one).
  - busy_set with busy_idx == PC_IDX is ignored.
  - Port A and link writes do not touch busy.
- stall (combinational) = OR over k of (rek & busy[rak] & rak != PC_IDX).
  - With BYPASS=1, a term is suppressed when we_b is asserted and wa_b == rak in the same cycle.
  - stall has no effect on the register file itself; the pipeline control consumes it.

Test Plan:
- Assert reset mid-run after writing 0xDEADBEEF to R3 -> rd1 (ra1=3) = 0 immediately; busy = 0; stall = 0.
- Apply we_a=1, wa_a=5, wd_a=0x11 together with we_b=1, wa_b=5, wd_b=0x22; BYPASS=1 -> rd1 (ra1=5) = 0x22 in the same cycle; R5 = 0x22 on the next cycle.
- Apply link_we=1 with pc_plus8=0x108 and ra2=14 -> rd2 = 0x104 on the next cycle. Also drive pc_plus8=0x200 with ra3=15 -> rd3 = 0x200 combinationally; a we_a write to index 15 has no effect.
- Assert busy_set with busy_idx=7, then re1=1, ra1=7 with no we_b -> stall = 1 and busy[7] = 1. Next, we_b to 7 with wd_b=0x55 -> stall = 0 that cycle, busy[7] = 0 afterward, rd1 = 0x55.
- Assert busy_set and we_b together, both on index 9 -> busy[9] remains 1.
- Set BYPASS=0 and write 0x77 to R2 via port A while ra1=2 -> rd1 shows the old value this cycle and 0x77 next cycle. Also: pc_plus8=0x0 with link_we -> R14 = 0xFFFFFFFC (wrap-around).
